// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory controller: FSM states,
// Funct3 size/sign encodings, the default timeout and the alignment rule.
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP
   } state_e;

   localparam logic [1:0]  SZ_BYTE         = 2'b00;
   localparam logic [1:0]  SZ_HALF         = 2'b01;
   localparam logic [1:0]  SZ_WORD         = 2'b10;
   localparam int unsigned F3_UNS_BIT      = 2;
   localparam int unsigned TIMEOUT_CYC_DEF = 16;

   // Any size other than byte/half is handled as a word access.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      if (size == SZ_HALF) begin
         mis = off[0];
      end else if (size != SZ_BYTE) begin
         mis = (off != 2'b00);
      end
      return mis;
   endfunction

endpackage

// File: rtl/load_ext.sv
// Load-path formatting: picks the addressed byte/half lane out of the memory
// word and sign- or zero-extends it to 32 bits. Purely combinational.
module load_ext
   import mem_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   output logic [31:0] ext_o
);

   logic [31:0] sh;

   assign sh = rdata_i >> {off_i, 3'b000};

   always_comb begin
      ext_o = rdata_i;
      case (size_i)
         SZ_BYTE: ext_o = uns_i ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         SZ_HALF: ext_o = uns_i ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
         default: ext_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: IDLE/REQ/RESP handshake with timeout.
// Define MISALIGN_TRAP_EN to complete misaligned accesses at once with Err=1.
module data_mem_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] Addr,
   input  logic [31:0] WrData,
   output logic        Stall,
   output logic [31:0] RdData,
   output logic        Done,
   output logic        Err,
   output logic        MemReq,
   output logic        MemWe,
   output logic [31:0] MemAddr,
   output logic [3:0]  MemBe,
   output logic [31:0] MemWdata,
   input  logic [31:0] MemRdata,
   input  logic        MemAck
);

   localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   state_e      state_q;
   logic [CW-1:0] cnt_q;
   logic [31:2] addr_q;
   logic [1:0]  off_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic        we_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic        start;
   logic        mis_d;
   logic [1:0]  off_d;
   logic [31:0] ext_d;
   logic [3:0]  be;
   logic [31:0] wd;

   assign start = MemRead | MemWrite;
   assign mis_d = misaligned(Funct3[1:0], Addr[1:0]);
   // Misaligned accesses that are not trapped use lane offset 0.
   assign off_d = mis_d ? 2'b00 : Addr[1:0];

   load_ext u_load_ext (
      .rdata_i (MemRdata),
      .off_i   (off_q),
      .size_i  (size_q),
      .uns_i   (uns_q),
      .ext_o   (ext_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         off_q   <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  addr_q  <= Addr[31:2];
                  off_q   <= off_d;
                  wdata_q <= WrData;
                  size_q  <= Funct3[1:0];
                  uns_q   <= Funct3[F3_UNS_BIT];
                  we_q    <= MemWrite;
                  cnt_q   <= '0;
`ifdef MISALIGN_TRAP_EN
                  if (mis_d) begin
                     state_q <= ST_RESP;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= ST_REQ;
                  end
`else
                  state_q <= ST_REQ;
`endif
               end
            end
            ST_REQ: begin
               if (MemAck) begin
                  rdata_q <= we_q ? '0 : ext_d;
                  err_q   <= 1'b0;
                  state_q <= ST_RESP;
               end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state_q <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RESP: begin
               err_q   <= 1'b0;
               rdata_q <= '0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      be = 4'b1111;
      wd = wdata_q;
      case (size_q)
         SZ_BYTE: begin
            be = 4'b0001 << off_q;
            wd = {4{wdata_q[7:0]}};
         end
         SZ_HALF: begin
            be = 4'b0011 << {off_q[1], 1'b0};
            wd = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   assign Stall    = (state_q == ST_REQ) | ((state_q == ST_IDLE) & start);
   assign MemReq   = (state_q == ST_REQ);
   assign Done     = (state_q == ST_RESP);
   assign Err      = err_q;
   assign RdData   = rdata_q;
   assign MemWe    = MemReq & we_q;
   assign MemAddr  = MemReq ? {addr_q, 2'b00} : '0;
   assign MemBe    = MemReq ? be : '0;
   assign MemWdata = MemReq ? wd : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a driver issues accesses and queues the
// expected completion; a monitor pops and compares on every Done pulse.
module tb_data_mem_ctrl;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemRead = 1'b0, MemWrite = 1'b0;
   logic [2:0]  Funct3 = '0;
   logic [31:0] Addr = '0, WrData = '0;
   logic        Stall, Done, Err, MemReq, MemWe;
   logic [31:0] RdData, MemAddr, MemWdata;
   logic [3:0]  MemBe;
   logic [31:0] MemRdata = '0;
   logic        MemAck = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] rd;
      bit          chk_rd;
      bit          err;
      int          cyc;
   } exp_t;
   exp_t exp_q[$];

   data_mem_ctrl #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Funct3(Funct3), .Addr(Addr), .WrData(WrData), .Stall(Stall),
      .RdData(RdData), .Done(Done), .Err(Err), .MemReq(MemReq), .MemWe(MemWe),
      .MemAddr(MemAddr), .MemBe(MemBe), .MemWdata(MemWdata),
      .MemRdata(MemRdata), .MemAck(MemAck)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference load formatting: shift the word down, keep the access width,
   // then wrap into a negative value for signed loads with the top bit set.
   function automatic logic [31:0] model_load(logic [31:0] w, int off, int nb, bit uns);
      logic [31:0] v;
      v = w >> (8 * off);
      if (nb == 32) return v;
      v = v % (32'd1 << nb);
      if (!uns && v >= (32'd1 << (nb - 1))) v = v - (32'd1 << nb);
      return v;
   endfunction

   // ack_k: cycle (>=1) on which MemAck is given; 0 means never (timeout).
   task automatic do_access(input bit wr, input bit both, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdat,
                            input logic [31:0] mrd, input int ack_k);
      int nb, off;
      bit mis, trap;
      logic [3:0] ebe;
      logic [31:0] ewd;
      exp_t e;
      nb   = (f3[1:0] == 2'b00) ? 8 : (f3[1:0] == 2'b01) ? 16 : 32;
      mis  = (nb == 16 && addr[0]) || (nb == 32 && addr[1:0] != 2'b00);
`ifdef MISALIGN_TRAP_EN
      trap = mis;
`else
      trap = 1'b0;
`endif
      off  = mis ? 0 : int'(addr[1:0]);
      ebe  = (nb == 8) ? 4'(1 << off) : (nb == 16) ? 4'(3 << off) : 4'hF;
      ewd  = (nb == 8) ? wdat[7:0] * 32'h01010101 :
             (nb == 16) ? wdat[15:0] * 32'h00010001 : wdat;

      @(posedge clk); #1;
      MemWrite = wr; MemRead = !wr || both;
      Funct3 = f3; Addr = addr; WrData = wdat;
      e.err    = trap || (ack_k == 0);
      e.chk_rd = !wr || e.err;
      e.rd     = e.err ? 32'h0 : model_load(mrd, off, nb, f3[2]);
      e.cyc    = cyc + (trap ? 1 : (ack_k == 0) ? int'(TO) + 1 : ack_k + 1);
      exp_q.push_back(e);
      @(negedge clk);
      chk("stall_req_cycle", Stall, 1);
      chk("memreq_cycle0", MemReq, 0);
      @(posedge clk); #1;
      MemRead = 0; MemWrite = 0;
      Addr = $urandom; WrData = $urandom; Funct3 = 3'($urandom);
      if (trap) begin
         @(negedge clk);
         chk("trap_no_memreq", MemReq, 0);
      end else begin
         for (int c = 1; c <= 64; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            MemAck   = (c == ack_k);
            MemRdata = (c == ack_k) ? mrd : $urandom;
            @(negedge clk);
            chk("stall_in_req", Stall, 1);
            chk("memreq", MemReq, 1);
            if (c == 1) begin
               chk("memwe", MemWe, wr);
               chk("memaddr", MemAddr, {addr[31:2], 2'b00});
               chk("membe", MemBe, ebe);
               if (wr) chk("memwdata", MemWdata, ewd);
            end
            if (c == ack_k || (ack_k == 0 && c == int'(TO))) break;
         end
         @(posedge clk); #1;
         MemAck = 0;
      end
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (!reset && Done) begin
         if (exp_q.size() == 0) begin
            chk("done_without_request", 32'(exp_q.size()), 1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("err", {31'b0, Err}, {31'b0, e.err});
            if (e.chk_rd) chk("rddata", RdData, e.rd);
            chk("stall_in_resp", Stall, 0);
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", Stall, 0);
      chk("rst_done", Done, 0);
      chk("rst_err", Err, 0);
      chk("rst_memreq", MemReq, 0);
      chk("rst_memwe", MemWe, 0);
      chk("rst_memaddr", MemAddr, 0);
      chk("rst_membe", {28'b0, MemBe}, 0);
      chk("rst_memwdata", MemWdata, 0);
      chk("rst_rddata", RdData, 0);
      @(posedge clk); #1;
      reset = 0;

      do_access(0, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3);
      do_access(0, 0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 1);
      do_access(0, 0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 2);
      do_access(1, 0, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2);
      do_access(0, 0, 3'b010, 32'h400, 32'h0, 32'h0, 0);
      do_access(0, 0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 2);
      do_access(1, 1, 3'b000, 32'h505, 32'h000000A5, 32'h0, 1);

      // Reset in the second REQ cycle abandons the access.
      @(posedge clk); #1;
      MemRead = 1; Funct3 = 3'b010; Addr = 32'h300;
      @(posedge clk); #1;
      MemRead = 0;
      @(posedge clk); #1;
      reset = 1;
      @(negedge clk);
      chk("memreq_before_reset", MemReq, 1);
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("post_reset_memreq", MemReq, 0);
      chk("post_reset_stall", Stall, 0);
      chk("post_reset_done", Done, 0);
      do_access(1, 0, 3'b010, 32'h304, 32'h87654321, 32'h0, 2);

      for (int i = 0; i < 60; i++) begin
         bit wr;
         logic [1:0] sz;
         bit uns;
         int k;
         wr  = 1'($urandom_range(0, 1));
         sz  = 2'($urandom_range(0, 2));
         uns = wr ? 1'b0 : 1'($urandom_range(0, 1));
         k   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
         do_access(wr, 1'($urandom_range(0, 1)), {uns, sz}, $urandom, $urandom, $urandom, k);
      end

      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("pending_completions", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
